spi_peripheral: RTL



---
 rtl/spi_peripheral.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spi_peripheral.sv
// SPI mode-0 responder bridging a command/burst serial protocol onto a
// 128-entry, 8-bit register bus. All SPI pins are oversampled in the clk domain.
module spi_peripheral #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       csb,
  input  logic       mosi,
  output logic       miso,
  output logic [6:0] reg_addr,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy,
  output logic       frame_error
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_WRITE, S_READ_FETCH, S_READ
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] csb_sync_q, csb_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] sync_vld_q, sync_vld_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   csb_prev_q, csb_prev_d;
  logic [2:0]             bit_count_q, bit_count_d;
  logic [6:0]             rx_shift_q, rx_shift_d;
  logic [7:0]             tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic [6:0]             reg_addr_q, reg_addr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   frame_error_q, frame_error_d;

  logic sclk_s, csb_s, mosi_s, rise, fall, csb_fall;

  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev_q;
  assign fall     = ~sclk_s & sclk_prev_q;
  assign csb_fall = csb_prev_q & ~csb_s;

  // State and register stage
  always_ff @(posedge clk) begin
    rx_shift_q <= rx_shift_d;
    tx_shift_q <= tx_shift_d;
    if (rst) begin
      state_q       <= S_IDLE;
      sclk_sync_q   <= '0;
      csb_sync_q    <= '1;
      mosi_sync_q   <= '0;
      sync_vld_q    <= '0;
      sclk_prev_q   <= 1'b0;
      csb_prev_q    <= 1'b0;
      bit_count_q   <= 3'd0;
      miso_q        <= 1'b0;
      reg_addr_q    <= 7'd0;
      wr_valid_q    <= 1'b0;
      wr_data_q     <= 8'd0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_sync_q   <= sclk_sync_d;
      csb_sync_q    <= csb_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      sync_vld_q    <= sync_vld_d;
      sclk_prev_q   <= sclk_prev_d;
      csb_prev_q    <= csb_prev_d;
      bit_count_q   <= bit_count_d;
      miso_q        <= miso_d;
      reg_addr_q    <= reg_addr_d;
      wr_valid_q    <= wr_valid_d;
      wr_data_q     <= wr_data_d;
      frame_error_q <= frame_error_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    sclk_sync_d    = sclk_sync_q << 1;
    sclk_sync_d[0] = sclk;
    csb_sync_d     = csb_sync_q << 1;
    csb_sync_d[0]  = csb;
    mosi_sync_d    = mosi_sync_q << 1;
    mosi_sync_d[0] = mosi;
    sync_vld_d     = sync_vld_q << 1;
    sync_vld_d[0]  = 1'b1;
    sclk_prev_d    = sclk_s;
    // The reset value of csb_s is not a real sample, so it must not arm
    // the falling-edge detector; a csb held low through reset stays ignored.
    csb_prev_d     = csb_s & sync_vld_q[SYNC_STAGES-1];

    state_d       = state_q;
    bit_count_d   = bit_count_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    miso_d        = miso_q;
    reg_addr_d    = reg_addr_q;
    wr_valid_d    = 1'b0;
    wr_data_d     = wr_data_q;
    frame_error_d = 1'b0;

    if (wr_valid_q) reg_addr_d = reg_addr_q + 7'd1;

    if (state_q != S_IDLE && csb_s) begin
      state_d     = S_IDLE;
      miso_d      = 1'b0;
      bit_count_d = 3'd0;
      if (bit_count_q != 3'd0 && state_q != S_READ_FETCH) frame_error_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          bit_count_d = 3'd0;
          miso_d      = 1'b0;
          if (csb_fall) state_d = S_CMD;
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (rise) begin
            rx_shift_d  = {rx_shift_q[5:0], mosi_s};
            bit_count_d = bit_count_q + 3'd1;
            if (bit_count_q == 3'd7) begin
              reg_addr_d = {rx_shift_q[5:0], mosi_s};
              state_d    = rx_shift_q[6] ? S_READ_FETCH : S_WRITE;
            end
          end
        end
        S_WRITE: begin
          miso_d = 1'b0;
          if (rise) begin
            rx_shift_d  = {rx_shift_q[5:0], mosi_s};
            bit_count_d = bit_count_q + 3'd1;
            if (bit_count_q == 3'd7) begin
              wr_data_d  = {rx_shift_q, mosi_s};
              wr_valid_d = 1'b1;
            end
          end
        end
        S_READ_FETCH: begin
          tx_shift_d  = rd_data;
          bit_count_d = 3'd0;
          state_d     = S_READ;
        end
        S_READ: begin
          if (fall) begin
            miso_d     = tx_shift_q[7];
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
          // Completing a byte fetches the next one well before the next fall.
          if (rise) begin
            bit_count_d = bit_count_q + 3'd1;
            if (bit_count_q == 3'd7) begin
              reg_addr_d = reg_addr_q + 7'd1;
              state_d    = S_READ_FETCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy        = (state_q != S_IDLE);
    rd_req      = (state_q == S_READ_FETCH);
    miso        = miso_q;
    reg_addr    = reg_addr_q;
    wr_valid    = wr_valid_q;
    wr_data     = wr_data_q;
    frame_error = frame_error_q;
  end

endmodule
